// File: rtl/exec_branch_unit.sv
// -----------------------------------------------------------------------------
// exec_branch_unit
//
// Shared arithmetic block for the 5-stage MIPS pipeline:
//   - fetch  : PC incrementer (pc_f + 4)
//   - decode : branch-target adder and branch compare unit (BCU)
//   - execute: ALU plus the HI/LO multiply/divide registers
// Everything is combinational except the HI/LO registers.
//
// Ports:
//   clk              system clock, HI/LO update on the rising edge
//   rst_n            asynchronous active-low reset (clears HI/LO only)
//   pc_f             fetch PC               -> pc_plus_4_f = pc_f + 4
//   pc_plus_4_d      decode PC+4            -> pc_branch_d = pc_plus_4_d + (sext(imm16) << 2)
//   imm16            decode immediate
//   sig_bcu_control  branch compare select  -> branch
//   rd1, rd2         forwarded rs / rt values for the compare
//   src_a, src_b     ALU operands
//   shamt            shift amount
//   sig_alu_control  ALU operation select   -> result
//   hi, lo           HI / LO register contents
//
// Build option:
//   MULDIV_EN  when defined, MULT/MULTU/DIV/DIVU/MTHI/MTLO write HI/LO.
//              When undefined no multiplier or divider is built, those codes
//              produce result 0 and HI/LO stay at their reset value of 0.
// -----------------------------------------------------------------------------
module exec_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus_4_f,
  input  logic [WIDTH-1:0] pc_plus_4_d,
  input  logic [15:0]      imm16,
  output logic [WIDTH-1:0] pc_branch_d,
  input  logic [3:0]       sig_bcu_control,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             branch,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       sig_alu_control,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // BCU select codes
  localparam logic [3:0] BCU_BEQ  = 4'd1;
  localparam logic [3:0] BCU_BNE  = 4'd2;
  localparam logic [3:0] BCU_BLEZ = 4'd3;
  localparam logic [3:0] BCU_BGTZ = 4'd4;
  localparam logic [3:0] BCU_BLTZ = 4'd5;
  localparam logic [3:0] BCU_BGEZ = 4'd6;

  // ALU operation codes
  localparam logic [4:0] ALU_AND   = 5'd0;
  localparam logic [4:0] ALU_OR    = 5'd1;
  localparam logic [4:0] ALU_ADD   = 5'd2;
  localparam logic [4:0] ALU_XOR   = 5'd3;
  localparam logic [4:0] ALU_NOR   = 5'd4;
  localparam logic [4:0] ALU_SUB   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_LUI   = 5'd11;
  localparam logic [4:0] ALU_MULT  = 5'd12;
  localparam logic [4:0] ALU_MULTU = 5'd13;
  localparam logic [4:0] ALU_DIV   = 5'd14;
  localparam logic [4:0] ALU_DIVU  = 5'd15;
  localparam logic [4:0] ALU_MFHI  = 5'd16;
  localparam logic [4:0] ALU_MFLO  = 5'd17;
  localparam logic [4:0] ALU_MTHI  = 5'd18;
  localparam logic [4:0] ALU_MTLO  = 5'd19;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Adders
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] branch_offset;

  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  assign branch_offset = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign pc_plus_4_f   = pc_f + WIDTH'(4);
  assign pc_branch_d   = pc_plus_4_d + branch_offset;

  // ---------------------------------------------------------------------------
  // Branch compare unit (signed compares against zero use the sign bit)
  // ---------------------------------------------------------------------------
  logic rd1_zero;
  assign rd1_zero = (rd1 == '0);

  always_comb begin
    branch = 1'b0;
    case (sig_bcu_control)
      BCU_BEQ:  branch = (rd1 == rd2);
      BCU_BNE:  branch = (rd1 != rd2);
      BCU_BLEZ: branch = rd1[WIDTH-1] | rd1_zero;
      BCU_BGTZ: branch = ~rd1[WIDTH-1] & ~rd1_zero;
      BCU_BLTZ: branch = rd1[WIDTH-1];
      BCU_BGEZ: branch = ~rd1[WIDTH-1];
      default:  branch = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU result
  // ---------------------------------------------------------------------------
  logic slt_s;
  logic slt_u;

  assign slt_s = ($signed(src_a) < $signed(src_b));
  assign slt_u = (src_a < src_b);

  always_comb begin
    result = '0;
    case (sig_alu_control)
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_ADD:  result = src_a + src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_NOR:  result = ~(src_a | src_b);
      ALU_SUB:  result = src_a - src_b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, slt_u};
      ALU_SLL:  result = src_b << shamt;
      ALU_SRL:  result = src_b >> shamt;
      ALU_SRA:  result = $signed(src_b) >>> shamt;
      ALU_LUI:  result = {src_b[15:0], 16'h0000};
      // Reads see the registered value only; a write in the same cycle
      // becomes visible one cycle later.
      ALU_MFHI: result = hi_q;
      ALU_MFLO: result = lo_q;
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO:
                result = '0;
      default:  result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // HI/LO next-state
  // ---------------------------------------------------------------------------
`ifdef MULDIV_EN
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;

  // The low 2*WIDTH bits of the product of sign-extended operands equal the
  // signed product, so one multiplier form serves both cases.
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};

  // Division runs on magnitudes and fixes signs afterwards. This gives
  // truncation toward zero, a remainder with the dividend's sign, and handles
  // 0x80000000 / -1 naturally (magnitude 0x80000000 re-negates to itself).
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_comb begin
    div_signed = (sig_alu_control == ALU_DIV);
    a_neg      = div_signed & src_a[WIDTH-1];
    b_neg      = div_signed & src_b[WIDTH-1];
    mag_a      = a_neg ? (~src_a + WIDTH'(1)) : src_a;
    mag_b      = b_neg ? (~src_b + WIDTH'(1)) : src_b;
    q_mag      = '0;
    r_mag      = '0;
    if (mag_b != '0) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem  = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (sig_alu_control)
      ALU_MULT:  {hi_d, lo_d} = prod_s;
      ALU_MULTU: {hi_d, lo_d} = prod_u;
      ALU_DIV, ALU_DIVU: begin
        // Divide by zero leaves HI/LO untouched.
        if (src_b != '0) begin
          lo_d = quot;
          hi_d = rem;
        end
      end
      ALU_MTHI:  hi_d = src_a;
      ALU_MTLO:  lo_d = src_a;
      default: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    endcase
  end
`else
  // Without multiply/divide support HI/LO never change after reset.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_exec_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_branch_unit
//
// Self-checking bench for exec_branch_unit. Expected values are pushed into a
// scoreboard queue when stimulus is applied and popped when the DUT output is
// sampled. HI/LO expectations follow the MULDIV_EN build option.
// -----------------------------------------------------------------------------
module tb_exec_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;
  logic [31:0] pc_plus_4_d;
  logic [15:0] imm16;
  logic [31:0] pc_branch_d;
  logic [3:0]  sig_bcu_control;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        branch;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic [4:0]  sig_alu_control;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  exec_branch_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_f            (pc_f),
    .pc_plus_4_f     (pc_plus_4_f),
    .pc_plus_4_d     (pc_plus_4_d),
    .imm16           (imm16),
    .pc_branch_d     (pc_branch_d),
    .sig_bcu_control (sig_bcu_control),
    .rd1             (rd1),
    .rd2             (rd2),
    .branch          (branch),
    .src_a           (src_a),
    .src_b           (src_b),
    .shamt           (shamt),
    .sig_alu_control (sig_alu_control),
    .result          (result),
    .hi              (hi),
    .lo              (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  // ---------------- stimulus tables ----------------
  localparam logic [31:0] AD_PCF [3] = '{32'h00400000, 32'hFFFFFFFC, 32'h12345678};
  localparam logic [31:0] AD_PCD [3] = '{32'h00400010, 32'h00400010, 32'h00000000};
  localparam logic [15:0] AD_IMM [3] = '{16'hFFFE, 16'h0003, 16'h8000};
  localparam logic [31:0] AD_EF  [3] = '{32'h00400004, 32'h00000000, 32'h1234567C};
  localparam logic [31:0] AD_EB  [3] = '{32'h00400008, 32'h0040001C, 32'hFFFE0000};

  localparam int NB = 16;
  localparam logic [31:0] BC_R1 [NB] = '{32'd5, 32'd5, 32'd5, 32'd5,
    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd5, 32'd1, 32'h80000000};
  localparam logic [31:0] BC_R2 [NB] = '{32'd5, 32'd5, 32'd6, 32'd6,
    32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
    32'd5, 32'd5, 32'd0, 32'd0};
  localparam logic [3:0]  BC_OP [NB] = '{4'd1, 4'd2, 4'd2, 4'd1,
    4'd5, 4'd3, 4'd4, 4'd6, 4'd3, 4'd4, 4'd6, 4'd5, 4'd0, 4'd9, 4'd4, 4'd15};
  localparam bit          BC_EX [NB] = '{1'b1, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  localparam int NA = 16;
  localparam logic [4:0]  AL_OP [NA] = '{5'd2, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11,
    5'd0, 5'd1, 5'd3, 5'd4, 5'd8, 5'd9, 5'd6, 5'd7, 5'd20, 5'd31};
  localparam logic [31:0] AL_A [NA] = '{32'h7FFFFFFF, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'd0, 32'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
    32'd0, 32'd0, 32'd1, 32'd1, 32'hDEADBEEF, 32'hDEADBEEF};
  localparam logic [31:0] AL_B [NA] = '{32'd1, 32'd5, 32'd1, 32'd1,
    32'h80000000, 32'hFFFF1234, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
    32'd1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
  localparam logic [4:0]  AL_SH [NA] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0,
    5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
  localparam logic [31:0] AL_EX [NA] = '{32'h80000000, 32'hFFFFFFFE, 32'd1, 32'd0,
    32'hF8000000, 32'h12340000, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
    32'h80000000, 32'h08000000, 32'd0, 32'd1, 32'd0, 32'd0};

  localparam int NM = 19;
  localparam logic [4:0]  MD_OP [NM] = '{5'd12, 5'd17, 5'd13, 5'd16, 5'd14, 5'd15,
    5'd14, 5'd14, 5'd15, 5'd14, 5'd18, 5'd19, 5'd16, 5'd0, 5'd12, 5'd12, 5'd20,
    5'd14, 5'd17};
  localparam logic [31:0] MD_A [NM] = '{32'hFFFFFFFD, 32'd0, 32'hFFFFFFFF, 32'd0,
    32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'd100, 32'd7, 32'h0000ABCD,
    32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5,
    32'hFFFFFFF9, 32'd0};
  localparam logic [31:0] MD_B [NM] = '{32'd7, 32'd0, 32'd2, 32'd0,
    32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd0,
    32'd0, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5,
    32'hFFFFFFFE, 32'd0};
  localparam logic [31:0] MD_NH [NM] = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'd0,
    32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'h0000ABCD,
    32'd0, 32'd0, 32'd0, 32'h3FFFFFFF, 32'h40000000, 32'd0, 32'hFFFFFFFF, 32'd0};
  localparam logic [31:0] MD_NL [NM] = '{32'hFFFFFFEB, 32'd0, 32'hFFFFFFFE, 32'd0,
    32'hFFFFFFFD, 32'd0, 32'd0, 32'h80000000, 32'd14, 32'hFFFFFFFD, 32'd0,
    32'h12345678, 32'd0, 32'd0, 32'h00000001, 32'h00000000, 32'd0, 32'd3, 32'd0};
  localparam bit MD_WH [NM] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit MD_WL [NM] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    pc_f = '0; pc_plus_4_d = '0; imm16 = '0; sig_bcu_control = '0;
    rd1 = '0; rd2 = '0; src_a = '0; src_b = '0; shamt = '0; sig_alu_control = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{"reset_hi", 32'd0});
    exp_q.push_back('{"reset_lo", 32'd0});
    e = exp_q.pop_front(); checks++;
    if (hi !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, hi, e.exp); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, lo, e.exp); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released, hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_adders();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_f = AD_PCF[i]; pc_plus_4_d = AD_PCD[i]; imm16 = AD_IMM[i];
      exp_q.push_back('{"pc_plus_4_f", AD_EF[i]});
      exp_q.push_back('{"pc_branch_d", AD_EB[i]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (pc_plus_4_f !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, pc_plus_4_f, e.exp); end
      e = exp_q.pop_front(); checks++;
      if (pc_branch_d !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, pc_branch_d, e.exp); end
      $display("adders pc_f=%h pc4d=%h imm=%h -> %h %h", pc_f, pc_plus_4_d, imm16, pc_plus_4_f, pc_branch_d);
    end
  endtask

  task automatic test_bcu();
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      rd1 = BC_R1[i]; rd2 = BC_R2[i]; sig_bcu_control = BC_OP[i];
      exp_q.push_back('{"bcu", {31'd0, BC_EX[i]}});
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, branch} !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %0d expected %0d", e.name, i, BC_OP[i], branch, e.exp); end
      $display("bcu op=%0d rd1=%h rd2=%h -> branch=%0d", sig_bcu_control, rd1, rd2, branch);
    end
    sig_bcu_control = '0;
  endtask

  task automatic test_alu();
    exp_t e;
    logic [31:0] a, b;
    for (int i = 0; i < NA; i++) begin
      @(negedge clk);
      sig_alu_control = AL_OP[i]; src_a = AL_A[i]; src_b = AL_B[i]; shamt = AL_SH[i];
      exp_q.push_back('{"alu", AL_EX[i]});
      #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %h expected %h", e.name, i, AL_OP[i], result, e.exp); end
      $display("alu op=%0d a=%h b=%h sh=%0d -> %h", sig_alu_control, src_a, src_b, shamt, result);
    end
    // Random wrap-around ADD/SUB
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      sig_alu_control = (i % 2 == 0) ? 5'd2 : 5'd5; src_a = a; src_b = b; shamt = '0;
      exp_q.push_back('{"alu_rand", (i % 2 == 0) ? a + b : a - b});
      #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, result, e.exp); end
      $display("alu op=%0d a=%h b=%h -> %h", sig_alu_control, src_a, src_b, result);
    end
    sig_alu_control = '0;
  endtask

  task automatic test_muldiv();
    exp_t e;
    logic [31:0] r_exp;
    for (int i = 0; i < NM; i++) begin
      @(negedge clk);
      sig_alu_control = MD_OP[i]; src_a = MD_A[i]; src_b = MD_B[i];
      if (MD_OP[i] == 5'd16)      r_exp = hi_m;
      else if (MD_OP[i] == 5'd17) r_exp = lo_m;
      else if (MD_OP[i] == 5'd0)  r_exp = MD_A[i] & MD_B[i];
      else                        r_exp = 32'd0;
      exp_q.push_back('{"md_result", r_exp});
      #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %h expected %h", e.name, i, MD_OP[i], result, e.exp); end
      @(posedge clk);
      if (MD && MD_WH[i]) hi_m = MD_NH[i];
      if (MD && MD_WL[i]) lo_m = MD_NL[i];
      exp_q.push_back('{"md_hi", hi_m});
      exp_q.push_back('{"md_lo", lo_m});
      #1;
      e = exp_q.pop_front(); checks++;
      if (hi !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %h expected %h", e.name, i, MD_OP[i], hi, e.exp); end
      e = exp_q.pop_front(); checks++;
      if (lo !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %h expected %h", e.name, i, MD_OP[i], lo, e.exp); end
      $display("muldiv op=%0d a=%h b=%h -> result=%h hi=%h lo=%h", MD_OP[i], MD_A[i], MD_B[i], r_exp, hi, lo);
    end
    sig_alu_control = '0;
  endtask

  // Random MTHI/MTLO/MFHI/MFLO/AND stream: checks no same-cycle bypass.
  task automatic test_back_to_back();
    exp_t e;
    logic [4:0]  op;
    logic [31:0] a, b, r_exp;
    int sel;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sel = $urandom_range(0, 4);
      case (sel)
        0: op = 5'd18;
        1: op = 5'd19;
        2: op = 5'd16;
        3: op = 5'd17;
        default: op = 5'd0;
      endcase
      a = $urandom; b = $urandom;
      sig_alu_control = op; src_a = a; src_b = b;
      if (op == 5'd16)      r_exp = hi_m;
      else if (op == 5'd17) r_exp = lo_m;
      else if (op == 5'd0)  r_exp = a & b;
      else                  r_exp = 32'd0;
      exp_q.push_back('{"b2b_result", r_exp});
      exp_q.push_back('{"b2b_pre_hi", hi_m});
      exp_q.push_back('{"b2b_pre_lo", lo_m});
      #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e.exp) begin failures++; $display("FAIL %s[%0d] op=%0d: got %h expected %h", e.name, i, op, result, e.exp); end
      e = exp_q.pop_front(); checks++;
      if (hi !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, hi, e.exp); end
      e = exp_q.pop_front(); checks++;
      if (lo !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, lo, e.exp); end
      @(posedge clk);
      if (MD && op == 5'd18) hi_m = a;
      if (MD && op == 5'd19) lo_m = a;
      #1;
      exp_q.push_back('{"b2b_hi", hi_m});
      exp_q.push_back('{"b2b_lo", lo_m});
      e = exp_q.pop_front(); checks++;
      if (hi !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, hi, e.exp); end
      e = exp_q.pop_front(); checks++;
      if (lo !== e.exp) begin failures++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, lo, e.exp); end
      $display("b2b op=%0d a=%h -> result=%h hi=%h lo=%h", op, a, result, hi, lo);
    end
    sig_alu_control = '0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    // Load nonzero values
    @(negedge clk);
    sig_alu_control = 5'd18; src_a = 32'h000055AA;
    @(posedge clk);
    if (MD) hi_m = 32'h000055AA;
    @(negedge clk);
    sig_alu_control = 5'd19; src_a = 32'h0000AA55;
    @(posedge clk);
    if (MD) lo_m = 32'h0000AA55;
    #1;
    exp_q.push_back('{"ar_loaded_hi", hi_m});
    exp_q.push_back('{"ar_loaded_lo", lo_m});
    e = exp_q.pop_front(); checks++;
    if (hi !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, hi, e.exp); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, lo, e.exp); end
    // Assert reset between edges; clear must be immediate
    #2;
    sig_alu_control = 5'd18; src_a = 32'hFFFF0000; src_b = 32'd0;
    rst_n = 1'b0;
    hi_m = '0; lo_m = '0;
    #1;
    exp_q.push_back('{"ar_imm_hi", 32'd0});
    exp_q.push_back('{"ar_imm_lo", 32'd0});
    e = exp_q.pop_front(); checks++;
    if (hi !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, hi, e.exp); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, lo, e.exp); end
    // Held at zero across edges even with a write op present
    repeat (2) @(posedge clk);
    #1;
    sig_alu_control = 5'd2; src_a = 32'd1; src_b = 32'd2;
    #1;
    exp_q.push_back('{"ar_hold_hi", 32'd0});
    exp_q.push_back('{"ar_hold_lo", 32'd0});
    exp_q.push_back('{"ar_comb_add", 32'd3});
    e = exp_q.pop_front(); checks++;
    if (hi !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, hi, e.exp); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, lo, e.exp); end
    e = exp_q.pop_front(); checks++;
    if (result !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, result, e.exp); end
    @(negedge clk);
    sig_alu_control = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{"ar_after_hi", hi_m});
    e = exp_q.pop_front(); checks++;
    if (hi !== e.exp) begin failures++; $display("FAIL %s: got %h expected %h", e.name, hi, e.exp); end
    $display("async reset: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_adders();
    test_bcu();
    test_alu();
    test_muldiv();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_branch_unit.md
Name: exec_branch_unit

Overview:
Combined arithmetic block for the 5-stage MIPS pipeline: PC incrementer (fetch), branch-target adder and branch comparison unit (decode), and ALU with HI/LO multiply/divide registers (execute). All datapaths are combinational except HI/LO. The block replaces the separate adder, ALU and branch-compare instances in the core.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  system clock; HI/LO update on rising edge
rst_n  in  1  asynchronous active-low reset
pc_f  in  32  fetch-stage PC
pc_plus_4_f  out  32  pc_f + 4
pc_plus_4_d  in  32  decode-stage PC+4
imm16  in  16  decode-stage instruction immediate [15:0]
pc_branch_d  out  32  branch target
sig_bcu_control  in  4  branch compare select
rd1  in  32  forwarded rs value (decode)
rd2  in  32  forwarded rt value (decode)
branch  out  1  branch condition true
src_a  in  32  ALU operand A
src_b  in  32  ALU operand B
shamt  in  5  shift amount
sig_alu_control  in  5  ALU operation select
result  out  32  ALU result
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Adders: pc_plus_4_f = pc_f + 4, modulo 2^32. pc_branch_d = pc_plus_4_d + (sign-extended imm16 << 2), modulo 2^32. No carry or overflow outputs.
- BCU (signed compares, combinational):
  - 0: branch = 0.
  - 1 BEQ: rd1 == rd2.
  - 2 BNE: rd1 != rd2.
  - 3 BLEZ: rd1 <= 0.
  - 4 BGTZ: rd1 > 0.
  - 5 BLTZ: rd1 < 0.
  - 6 BGEZ: rd1 >= 0.
  - 7–15: branch = 0.
- ALU result (combinational):
  - 0 AND; 1 OR; 2 ADD; 3 XOR; 4 NOR; 5 SUB.
  - 6 SLT (signed, result 1/0); 7 SLTU (unsigned, result 1/0).
  - 8 SLL src_b<<shamt; 9 SRL logical; 10 SRA arithmetic.
  - 11 LUI {src_b[15:0],16'h0}.
  - 12 MULT; 13 MULTU; 14 DIV; 15 DIVU.
  - 16 MFHI result = hi; 17 MFLO result = lo.
  - 18 MTHI; 19 MTLO.
  - 20–31: result = 0.
- ADD and SUB wrap on overflow; no trap.
- result is 0 for codes 12–15 and 18–19.
- HI/LO register rules:
  - Update only at the rising clk edge.
  - MULT/MULTU: {hi,lo} <= signed/unsigned 64-bit product of src_a and src_b.
  - DIV/DIVU: lo <= quotient, hi <= remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0.
  - Divide by zero (src_b == 0): hi and lo unchanged.
  - MTHI: hi <= src_a. MTLO: lo <= src_a.
  - All other codes: hi and lo hold their values.
- MFHI/MFLO return the current registered value. A write issued in the same cycle is visible one cycle later; there is no internal bypass.
- Reset: rst_n low asynchronously clears hi and lo to 0. hi and lo stay 0 while rst_n is low. All combinational outputs are unaffected by reset.
- Code 0 is AND and leaves HI/LO untouched, so flushed bubbles (all-zero control) are harmless.

Optional Feature:
MULDIV_EN:
- Defined: codes 12–15 and 18–19 behave as specified above.
- Undefined: codes 12–15 and 18–19 produce result 0 and do not modify hi/lo. hi and lo stay 0 after reset, and MFHI/MFLO return 0. No multiplier or divider logic is synthesised.

Test Plan:
- pc_f=0x00400000 -> pc_plus_4_f=0x00400004. pc_plus_4_d=0x00400010, imm16=0xFFFE -> pc_branch_d=0x00400008. imm16=0x0003 -> 0x0040001C.
- BCU: rd1=rd2=5, code 1 -> branch=1. Code 2 -> 0. rd1=0xFFFFFFFF with codes 5, 3, 4, 6 -> 1, 1, 0, 0. Code 0 or 9 -> 0.
- ALU:
  - src_a=0x7FFFFFFF, src_b=1, ADD -> 0x80000000.
  - SUB 3-5 -> 0xFFFFFFFE.
  - SLT(-1,1)=1; SLTU(-1,1)=0.
  - SRA 0x80000000 by shamt 4 -> 0xF8000000.
  - LUI src_b=0x1234 -> 0x12340000.
- MULT -3×7 -> after one edge hi=0xFFFFFFFF, lo=0xFFFFFFEB; MFLO next cycle -> 0xFFFFFFEB. MULTU 0xFFFFFFFF×2 -> hi=1, lo=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi/lo unchanged. MTHI src_a=0xABCD -> hi=0xABCD.
- Load hi/lo with nonzero values, then pulse rst_n low between clock edges -> hi=lo=0 immediately, and they hold 0 until rst_n rises. With MULDIV_EN undefined, MULT 2×3 -> hi=lo=0.
